// File: rtl/core_pkg.sv
// Shared core types: ALU operation select, execute-unit FSM states and shift-amount width.
package core_pkg;

  localparam int SHAMT_W = 5;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_PASS_B = 4'd10,
    ALU_X      = 4'd15
  } alu_sel_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } exec_state_e;

endpackage

// File: rtl/alu_exec_unit_if.sv
// Request/result handshake bundle between an issuing stage (master) and alu_exec_unit (slave).
interface alu_exec_unit_if #(
  parameter int XLEN = 32
);
  import core_pkg::*;

  logic            op_valid_i;
  logic            op_ready_o;
  alu_sel_e        alu_sel_i;
  logic [XLEN-1:0] a_i;
  logic [XLEN-1:0] b_i;
  logic            res_valid_o;
  logic            res_ready_i;
  logic [XLEN-1:0] result_o;
  logic            illegal_o;

  modport master (
    output op_valid_i, alu_sel_i, a_i, b_i, res_ready_i,
    input  op_ready_o, res_valid_o, result_o, illegal_o
  );

  modport slave (
    input  op_valid_i, alu_sel_i, a_i, b_i, res_ready_i,
    output op_ready_o, res_valid_o, result_o, illegal_o
  );

endinterface

// File: rtl/alu_serial_shifter.sv
// One-bit-per-cycle shifter: holds the working operand and a shift-amount down-counter.
module alu_serial_shifter
  import core_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               i_load,
  input  logic               i_step,
  input  alu_sel_e           i_kind,
  input  logic [XLEN-1:0]    i_data,
  input  logic [SHAMT_W-1:0] i_shamt,
  output logic [XLEN-1:0]    o_next,
  output logic [SHAMT_W-1:0] o_count
);

  logic [XLEN-1:0]    r_data;
  logic [SHAMT_W-1:0] r_count;
  alu_sel_e           r_kind;
  logic [XLEN-1:0]    w_next;

  // o_next is the value after one more step, so the owner can capture the final result directly
  always_comb begin
    w_next = r_data;
    case (r_kind)
      ALU_SLL: w_next = {r_data[XLEN-2:0], 1'b0};
      ALU_SRL: w_next = {1'b0, r_data[XLEN-1:1]};
      ALU_SRA: w_next = {r_data[XLEN-1], r_data[XLEN-1:1]};
      default: w_next = r_data;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_data  <= '0;
      r_count <= '0;
      r_kind  <= ALU_ADD;
    end else if (i_load) begin
      r_data  <= i_data;
      r_count <= i_shamt;
      r_kind  <= i_kind;
    end else if (i_step) begin
      r_data  <= w_next;
      r_count <= r_count - SHAMT_W'(1);
    end
  end

  assign o_next  = w_next;
  assign o_count = r_count;

endmodule

// File: rtl/alu_exec_unit.sv
// Handshaked ALU execute unit with iterative shifts; define ALU_EXEC_FAST_SHIFT_EN for single-step shifts.
module alu_exec_unit
  import core_pkg::*;
#(
  parameter int XLEN = 32
) (
  input logic            clk_i,
  input logic            rst_i,
  alu_exec_unit_if.slave bus
);

  exec_state_e        r_state;
  exec_state_e        w_stateNext;
  logic [XLEN-1:0]    r_result;
  logic               r_illegal;
  logic [XLEN-1:0]    w_aluResult;
  logic               w_aluIllegal;
  logic               w_accept;
  logic               w_startShift;
  logic               w_shiftLast;
  logic [XLEN-1:0]    w_shiftNext;
  logic [SHAMT_W-1:0] w_shamt;

  assign w_shamt  = bus.b_i[SHAMT_W-1:0];
  assign w_accept = bus.op_valid_i && (r_state == IDLE) && !rst_i;

`ifdef ALU_EXEC_FAST_SHIFT_EN
  assign w_startShift = 1'b0;
  assign w_shiftLast  = 1'b0;
  assign w_shiftNext  = '0;
`else
  logic               w_isShift;
  logic [SHAMT_W-1:0] w_count;

  assign w_isShift = (bus.alu_sel_i == ALU_SLL) || (bus.alu_sel_i == ALU_SRL) ||
                     (bus.alu_sel_i == ALU_SRA);
  assign w_startShift = w_isShift && (w_shamt != '0);
  assign w_shiftLast  = (r_state == SHIFT) && (w_count == SHAMT_W'(1));

  alu_serial_shifter #(
    .XLEN(XLEN)
  ) u_shifter (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .i_load (w_accept && w_startShift),
    .i_step (r_state == SHIFT),
    .i_kind (bus.alu_sel_i),
    .i_data (bus.a_i),
    .i_shamt(w_shamt),
    .o_next (w_shiftNext),
    .o_count(w_count)
  );
`endif

  // Single-cycle result; in the iterative build a shift by zero simply passes operand A through
  always_comb begin
    w_aluResult  = '0;
    w_aluIllegal = 1'b0;
    case (bus.alu_sel_i)
      ALU_ADD:    w_aluResult = bus.a_i + bus.b_i;
      ALU_SUB:    w_aluResult = bus.a_i - bus.b_i;
      ALU_SLT:    w_aluResult = {{(XLEN-1){1'b0}}, $signed(bus.a_i) < $signed(bus.b_i)};
      ALU_SLTU:   w_aluResult = {{(XLEN-1){1'b0}}, bus.a_i < bus.b_i};
      ALU_XOR:    w_aluResult = bus.a_i ^ bus.b_i;
      ALU_OR:     w_aluResult = bus.a_i | bus.b_i;
      ALU_AND:    w_aluResult = bus.a_i & bus.b_i;
      ALU_PASS_B: w_aluResult = bus.b_i;
`ifdef ALU_EXEC_FAST_SHIFT_EN
      ALU_SLL:    w_aluResult = bus.a_i << w_shamt;
      ALU_SRL:    w_aluResult = bus.a_i >> w_shamt;
      ALU_SRA:    w_aluResult = $unsigned($signed(bus.a_i) >>> w_shamt);
`else
      ALU_SLL, ALU_SRL, ALU_SRA: w_aluResult = bus.a_i;
`endif
      default:    w_aluIllegal = 1'b1;
    endcase
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_stateNext = w_startShift ? SHIFT : DONE;
      SHIFT:   if (w_shiftLast) w_stateNext = DONE;
      DONE:    if (bus.res_ready_i) w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  // Result registers stay untouched while DONE waits, so the consumer sees a stable value
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= IDLE;
      r_result  <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      if (w_accept) begin
        r_result  <= w_aluResult;
        r_illegal <= w_aluIllegal;
      end else if (w_shiftLast) begin
        r_result <= w_shiftNext;
      end
    end
  end

  assign bus.op_ready_o  = (r_state == IDLE);
  assign bus.res_valid_o = (r_state == DONE);
  assign bus.result_o    = r_result;
  assign bus.illegal_o   = r_illegal;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed table-driven bench for alu_exec_unit; expected shift latency follows ALU_EXEC_FAST_SHIFT_EN.
module tb_alu_exec_unit;
  import core_pkg::*;

  localparam int XLEN = 32;
`ifdef ALU_EXEC_FAST_SHIFT_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  typedef struct {
    alu_sel_e    sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expRes;
    logic        expIll;
    int          expLat;
  } vec_t;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[18];

  alu_exec_unit_if #(.XLEN(XLEN)) bus ();

  alu_exec_unit #(.XLEN(XLEN)) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .bus  (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Advance past the next rising edge; sampling and driving happen 1ns after it
  task automatic nextCycle();
    @(posedge clk_i);
    #1;
  endtask

  // Presents one operation, lets it be accepted, then scrambles the inputs while the unit is busy
  task automatic applyStimulus(input alu_sel_e sel, input logic [31:0] a, input logic [31:0] b);
    bus.alu_sel_i  = sel;
    bus.a_i        = a;
    bus.b_i        = b;
    bus.op_valid_i = 1'b1;
    nextCycle();
    bus.op_valid_i = 1'b0;
    bus.alu_sel_i  = ALU_XOR;
    bus.a_i        = ~a;
    bus.b_i        = ~b;
  endtask

  task automatic runVector(input int idx, input vec_t v);
    int lat;
    applyStimulus(v.sel, v.a, v.b);
    checkOutput($sformatf("v%0d.opReadyBusy", idx), 32'(bus.op_ready_o), 32'd0);
    lat = 1;
    while (!bus.res_valid_o && lat < 64) begin
      nextCycle();
      lat++;
    end
    checkOutput($sformatf("v%0d.latency", idx), 32'(lat), 32'(v.expLat));
    checkOutput($sformatf("v%0d.result", idx), bus.result_o, v.expRes);
    checkOutput($sformatf("v%0d.illegal", idx), 32'(bus.illegal_o), 32'(v.expIll));
    bus.res_ready_i = 1'b1;
    nextCycle();
    bus.res_ready_i = 1'b0;
    checkOutput($sformatf("v%0d.backToIdle", idx), 32'({bus.res_valid_o, bus.op_ready_o}), 32'b01);
  endtask

  initial begin
    bit seen;

    vecs[0]  = '{ALU_ADD,    32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1};
    vecs[1]  = '{ALU_SUB,    32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 1};
    vecs[2]  = '{ALU_SLT,    32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1};
    vecs[3]  = '{ALU_SLTU,   32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1};
    vecs[4]  = '{ALU_SLT,    32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1};
    vecs[5]  = '{ALU_SLTU,   32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1};
    vecs[6]  = '{ALU_XOR,    32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 1};
    vecs[7]  = '{ALU_OR,     32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1'b0, 1};
    vecs[8]  = '{ALU_AND,    32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1};
    vecs[9]  = '{ALU_PASS_B, 32'h0000_DEAD, 32'hCAFE_BABE, 32'hCAFE_BABE, 1'b0, 1};
    vecs[10] = '{ALU_SRA,    32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 1'b0, FAST ? 1 : 5};
    vecs[11] = '{ALU_SLL,    32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 1'b0, 1};
    vecs[12] = '{ALU_SLL,    32'h1234_5678, 32'h0000_0020, 32'h1234_5678, 1'b0, 1};
    vecs[13] = '{ALU_SLL,    32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 1'b0, FAST ? 1 : 32};
    vecs[14] = '{ALU_SRL,    32'h8000_0000, 32'h0000_003F, 32'h0000_0001, 1'b0, FAST ? 1 : 32};
    vecs[15] = '{ALU_SRL,    32'hF000_0000, 32'h0000_0004, 32'h0F00_0000, 1'b0, FAST ? 1 : 5};
    vecs[16] = '{ALU_SRA,    32'h7FFF_FFF0, 32'h0000_0004, 32'h07FF_FFFF, 1'b0, FAST ? 1 : 5};
    vecs[17] = '{alu_sel_e'(4'd12), 32'h1111_1111, 32'h2222_2222, 32'h0000_0000, 1'b1, 1};

    // Reset held with a valid request: must stay ready and never accept
    bus.op_valid_i  = 1'b1;
    bus.alu_sel_i   = ALU_ADD;
    bus.a_i         = 32'd1;
    bus.b_i         = 32'd1;
    bus.res_ready_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      nextCycle();
      checkOutput($sformatf("rst%0d.opReady", c), 32'(bus.op_ready_o), 32'd1);
      checkOutput($sformatf("rst%0d.resValid", c), 32'(bus.res_valid_o), 32'd0);
    end
    checkOutput("rst.result", bus.result_o, 32'd0);
    checkOutput("rst.illegal", 32'(bus.illegal_o), 32'd0);
    bus.op_valid_i = 1'b0;
    rst_i = 1'b0;
    nextCycle();
    checkOutput("postRst.resValid", 32'(bus.res_valid_o), 32'd0);

    for (int i = 0; i < 18; i++) runVector(i, vecs[i]);

    // ALU_X held un-consumed while a new request waits; it is taken only after the consume cycle
    applyStimulus(ALU_X, 32'h0000_1234, 32'h0000_5678);
    checkOutput("aluX.result", bus.result_o, 32'd0);
    checkOutput("aluX.illegal", 32'(bus.illegal_o), 32'd1);
    checkOutput("aluX.resValid", 32'(bus.res_valid_o), 32'd1);
    bus.alu_sel_i  = ALU_ADD;
    bus.a_i        = 32'd2;
    bus.b_i        = 32'd3;
    bus.op_valid_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      nextCycle();
      checkOutput($sformatf("hold%0d.result", c), bus.result_o, 32'd0);
      checkOutput($sformatf("hold%0d.illegal", c), 32'(bus.illegal_o), 32'd1);
      checkOutput($sformatf("hold%0d.opReady", c), 32'(bus.op_ready_o), 32'd0);
      checkOutput($sformatf("hold%0d.resValid", c), 32'(bus.res_valid_o), 32'd1);
    end
    bus.res_ready_i = 1'b1;
    nextCycle();
    bus.res_ready_i = 1'b0;
    checkOutput("consume.state", 32'({bus.res_valid_o, bus.op_ready_o}), 32'b01);
    nextCycle();
    bus.op_valid_i = 1'b0;
    checkOutput("issue2.resValid", 32'(bus.res_valid_o), 32'd1);
    checkOutput("issue2.result", bus.result_o, 32'd5);
    checkOutput("issue2.illegal", 32'(bus.illegal_o), 32'd0);
    bus.res_ready_i = 1'b1;
    nextCycle();
    bus.res_ready_i = 1'b0;

    // Reset five cycles into a long SRL: the pending result must never appear
    applyStimulus(ALU_SRL, 32'hFFFF_FFFF, 32'd20);
    repeat (4) nextCycle();
    rst_i = 1'b1;
    nextCycle();
    checkOutput("abort.opReady", 32'(bus.op_ready_o), 32'd1);
    checkOutput("abort.resValid", 32'(bus.res_valid_o), 32'd0);
    checkOutput("abort.result", bus.result_o, 32'd0);
    checkOutput("abort.illegal", 32'(bus.illegal_o), 32'd0);
    rst_i = 1'b0;
    seen = 1'b0;
    repeat (30) begin
      nextCycle();
      if (bus.res_valid_o) seen = 1'b1;
    end
    checkOutput("abort.noResult", 32'(seen), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have port clk_i, input, 1, single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_i, input, 1, synchronous active-high reset.
REQ-004 SHALL have port op_valid_i, input, 1, operation request valid.
REQ-005 SHALL have port op_ready_o, output, 1, unit can accept an operation.
REQ-006 SHALL have port alu_sel_i, input, alu_sel_e, operation select from the ALU control decoder.
REQ-007 SHALL have port a_i, input, XLEN, operand A (rs1).
REQ-008 SHALL have port b_i, input, XLEN, operand B (rs2 or immediate).
REQ-009 SHALL have port res_valid_o, output, 1, result valid.
REQ-010 SHALL have port res_ready_i, input, 1, consumer accepts result.
REQ-011 SHALL have port result_o, output, XLEN, operation result.
REQ-012 SHALL have port illegal_o, output, 1, accompanies result; operation was ALU_X or unknown.

Function
REQ-013 SHALL accept an operation when op_valid_i and op_ready_o are both high on a clock edge, capturing alu_sel_i, a_i and b_i.
REQ-014 SHALL implement FSM states IDLE, SHIFT, DONE; op_ready_o high only in IDLE; res_valid_o high only in DONE.
REQ-015 SHALL move IDLE->DONE on accept for non-shift ops, and for shifts with shamt = b_i[4:0] = 0.
REQ-016 SHALL move IDLE->SHIFT on accept for ALU_SLL/ALU_SRL/ALU_SRA with shamt != 0, loading a 5-bit down-counter with shamt.
REQ-017 SHALL, in SHIFT, shift the working register one bit per cycle (SLL: zero-fill LSB; SRL: zero-fill MSB; SRA: replicate MSB), decrement the counter, and go to DONE in the cycle the counter reaches 0; shift latency = shamt cycles + 1.
REQ-018 SHALL compute ADD a+b, SUB a-b (both modulo 2^XLEN), SLT signed a<b ->1/0, SLTU unsigned a<b ->1/0, XOR, OR, AND, PASS_B = b.
REQ-019 SHALL, for ALU_X or any undefined encoding, produce result_o = 0 and illegal_o = 1 with single-cycle latency; illegal_o = 0 otherwise.
REQ-020 SHALL hold result_o and illegal_o stable in DONE until res_ready_i is high, then return to IDLE.
REQ-021 SHALL NOT accept a new operation in the cycle a result is consumed; minimum issue interval is 2 cycles.
REQ-022 SHALL ignore changes to alu_sel_i, a_i, b_i and op_valid_i while not in IDLE.
REQ-023 SHALL use only b_i[4:0] as shift amount; b_i[XLEN-1:5] ignored for shifts.

Reset
REQ-024 SHALL, on rst_i high at a clock edge, enter IDLE with op_ready_o = 1, res_valid_o = 0, result_o = 0, illegal_o = 0, counter = 0.
REQ-025 SHALL abort any operation in SHIFT or DONE on reset; the pending result is discarded and never presented.
REQ-026 SHALL hold op_ready_o = 1 during reset-asserted cycles but SHALL NOT accept an operation while rst_i is high.

Configuration
REQ-027 SHALL, when macro ALU_EXEC_FAST_SHIFT_EN is defined, perform SLL/SRL/SRA in one step (IDLE->DONE, latency 1, SHIFT state unused/unreachable).
REQ-028 SHALL, when ALU_EXEC_FAST_SHIFT_EN is undefined, use the iterative shifter of REQ-016/017; all other behaviour identical.

Structure
REQ-029 SHALL take alu_sel_e from core_pkg; the FSM state enum exec_state_e and constant SHAMT_W = 5 SHALL be added to core_pkg.
REQ-030 SHALL place the one-bit-per-cycle shift datapath in sub-module alu_serial_shifter; the rest stays flat.

Verification
REQ-031 SHALL check ADD a=0xFFFF_FFFF b=0x1 -> result 0x0000_0000 one cycle after accept, illegal_o=0.
REQ-032 SHALL check SLT a=0xFFFF_FFFF b=0x1 -> 1, and SLTU same operands -> 0.
REQ-033 SHALL check SRA a=0x8000_0000 b=0x0000_0024 (shamt 4) -> 0xF800_0000 with res_valid_o at accept+5 (iterative) or accept+1 (fast).
REQ-034 SHALL check SLL with shamt 0, a=0x1234_5678 -> 0x1234_5678 at accept+1; and shamt 31, a=0x1 -> 0x8000_0000 at accept+32 (iterative).
REQ-035 SHALL check ALU_X -> result 0, illegal_o=1; then hold res_ready_i low 3 cycles -> result stable, op_ready_o low.
REQ-036 SHALL check rst_i asserted mid-SHIFT (SRL, shamt 20, cycle 5) -> next cycle IDLE, op_ready_o=1, res_valid_o=0, no result emitted.
